// File: rtl/tank_motion.sv
// Per-frame tank position/heading generator feeding the color mapper.
// Optional macro TANK_WALL_BOUNCE_EN reflects the heading off any wall the tank is clamped against.
module tank_motion #(
    parameter int START_X = 320,
    parameter int START_Y = 240,
    parameter int SIZE    = 4,
    parameter int SPEED   = 2,
    parameter int X_MIN   = 0,
    parameter int X_MAX   = 639,
    parameter int Y_MIN   = 0,
    parameter int Y_MAX   = 479
) (
    input  logic       Clk,
    input  logic       Reset,
    input  logic       frame_clk,
    input  logic       fwd,
    input  logic       back,
    input  logic       rot_cw,
    input  logic       rot_ccw,
    output logic [9:0] TankX,
    output logic [9:0] TankY,
    output logic [9:0] Tank_size,
    output logic [7:0] sin_out,
    output logic [7:0] cos_out,
    output logic [4:0] angle_idx,
    output logic       update_done,
    output logic [2:0] dbg_state_o
);
    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        TURN    = 3'd1,
        LOOKUP  = 3'd2,
        MOVE    = 3'd3,
        CLAMP   = 3'd4,
        REFLECT = 3'd5
    } state_e;

    localparam logic [9:0]         XLO = 10'(X_MIN + SIZE);
    localparam logic [9:0]         XHI = 10'(X_MAX - SIZE);
    localparam logic [9:0]         YLO = 10'(Y_MIN + SIZE);
    localparam logic [9:0]         YHI = 10'(Y_MAX - SIZE);
    localparam logic [15:0]        PX0 = 16'(START_X * 64);
    localparam logic [15:0]        PY0 = 16'(START_Y * 64);
    localparam logic signed [16:0] SPD = 17'(SPEED);

    // Quarter-wave table; other quadrants by symmetry.
    function automatic logic signed [7:0] cos_lut(input logic [4:0] k);
        logic [4:0]        t;
        logic              neg;
        logic signed [7:0] b;
        if (k <= 5'd8)       begin t = k;          neg = 1'b0; end
        else if (k <= 5'd16) begin t = 5'd16 - k;  neg = 1'b1; end
        else if (k <= 5'd24) begin t = k - 5'd16;  neg = 1'b1; end
        else                 begin t = 5'd0 - k;   neg = 1'b0; end
        case (t[3:0])
            4'd0:    b = 8'sd64;
            4'd1:    b = 8'sd63;
            4'd2:    b = 8'sd59;
            4'd3:    b = 8'sd53;
            4'd4:    b = 8'sd45;
            4'd5:    b = 8'sd36;
            4'd6:    b = 8'sd24;
            4'd7:    b = 8'sd12;
            default: b = 8'sd0;
        endcase
        return neg ? -b : b;
    endfunction

    function automatic logic signed [7:0] sin_lut(input logic [4:0] k);
        return cos_lut(k - 5'd8);
    endfunction

    // Negative 17-bit results count as below the minimum; clamping zeroes the fraction.
    function automatic logic [15:0] clamp_val(input logic signed [16:0] v,
                                              input logic [9:0] lo, input logic [9:0] hi);
        if (v[16] || v[15:6] < lo) return {lo, 6'd0};
        if (v[15:6] > hi)          return {hi, 6'd0};
        return v[15:0];
    endfunction

`ifdef TANK_WALL_BOUNCE_EN
    function automatic logic clamp_hit(input logic signed [16:0] v,
                                       input logic [9:0] lo, input logic [9:0] hi);
        return v[16] || (v[15:6] < lo) || (v[15:6] > hi);
    endfunction
`endif

    state_e            state_q, state_d;
    logic              fs1_q, fs2_q, fs3_q;
    logic              tick;
    logic [3:0]        ctl_q, ctl_d;
    logic [4:0]        idx_q, idx_d;
    logic signed [7:0] sin_q, sin_d, cos_q, cos_d;
    logic [15:0]       px_q, px_d, py_q, py_d;
    logic signed [16:0] mx_q, mx_d, my_q, my_d;
    logic signed [16:0] dx, dy;
    logic [9:0]        x_out_q, x_out_d, y_out_q, y_out_d;
    logic [7:0]        sin_out_q, sin_out_d, cos_out_q, cos_out_d;
    logic [4:0]        idx_out_q, idx_out_d;
    logic              done_q, done_d;
`ifdef TANK_WALL_BOUNCE_EN
    logic [4:0]        refl;
`endif

    assign tick = fs2_q & ~fs3_q;

    always_comb begin
        state_d   = state_q;
        ctl_d     = ctl_q;
        idx_d     = idx_q;
        sin_d     = sin_q;
        cos_d     = cos_q;
        px_d      = px_q;
        py_d      = py_q;
        mx_d      = mx_q;
        my_d      = my_q;
        x_out_d   = x_out_q;
        y_out_d   = y_out_q;
        sin_out_d = sin_out_q;
        cos_out_d = cos_out_q;
        idx_out_d = idx_out_q;
        done_d    = 1'b0;
        dx        = $signed({{9{cos_q[7]}}, cos_q}) * SPD;
        dy        = $signed({{9{sin_q[7]}}, sin_q}) * SPD;
`ifdef TANK_WALL_BOUNCE_EN
        refl      = idx_q;
`endif
        case (state_q)
            IDLE: if (tick) begin
                ctl_d   = {fwd, back, rot_cw, rot_ccw};
                state_d = TURN;
            end
            TURN: begin
                if (ctl_q[1] && !ctl_q[0])      idx_d = idx_q + 5'd1;
                else if (!ctl_q[1] && ctl_q[0]) idx_d = idx_q - 5'd1;
                state_d = LOOKUP;
            end
            LOOKUP: begin
                sin_d   = sin_lut(idx_q);
                cos_d   = cos_lut(idx_q);
                state_d = MOVE;
            end
            MOVE: begin
                mx_d = $signed({1'b0, px_q});
                my_d = $signed({1'b0, py_q});
                if (ctl_q[3] && !ctl_q[2]) begin
                    mx_d = mx_d + dx;
                    my_d = my_d + dy;
                end else if (!ctl_q[3] && ctl_q[2]) begin
                    mx_d = mx_d - dx;
                    my_d = my_d - dy;
                end
                state_d = CLAMP;
            end
            CLAMP: begin
                px_d = clamp_val(mx_q, XLO, XHI);
                py_d = clamp_val(my_q, YLO, YHI);
`ifdef TANK_WALL_BOUNCE_EN
                if (clamp_hit(mx_q, XLO, XHI)) refl = 5'd16 - refl;
                if (clamp_hit(my_q, YLO, YHI)) refl = 5'd0 - refl;
                idx_d   = refl;
                state_d = REFLECT;
`else
                x_out_d   = px_d[15:6];
                y_out_d   = py_d[15:6];
                sin_out_d = sin_q;
                cos_out_d = cos_q;
                idx_out_d = idx_q;
                done_d    = 1'b1;
                state_d   = IDLE;
`endif
            end
`ifdef TANK_WALL_BOUNCE_EN
            REFLECT: begin
                sin_d     = sin_lut(idx_q);
                cos_d     = cos_lut(idx_q);
                x_out_d   = px_q[15:6];
                y_out_d   = py_q[15:6];
                sin_out_d = sin_d;
                cos_out_d = cos_d;
                idx_out_d = idx_q;
                done_d    = 1'b1;
                state_d   = IDLE;
            end
`endif
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q   <= IDLE;
            fs1_q     <= 1'b0;
            fs2_q     <= 1'b0;
            fs3_q     <= 1'b0;
            ctl_q     <= 4'd0;
            idx_q     <= 5'd0;
            sin_q     <= 8'sd0;
            cos_q     <= 8'sd64;
            px_q      <= PX0;
            py_q      <= PY0;
            mx_q      <= 17'sd0;
            my_q      <= 17'sd0;
            x_out_q   <= PX0[15:6];
            y_out_q   <= PY0[15:6];
            sin_out_q <= 8'd0;
            cos_out_q <= 8'd64;
            idx_out_q <= 5'd0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            fs1_q     <= frame_clk;
            fs2_q     <= fs1_q;
            fs3_q     <= fs2_q;
            ctl_q     <= ctl_d;
            idx_q     <= idx_d;
            sin_q     <= sin_d;
            cos_q     <= cos_d;
            px_q      <= px_d;
            py_q      <= py_d;
            mx_q      <= mx_d;
            my_q      <= my_d;
            x_out_q   <= x_out_d;
            y_out_q   <= y_out_d;
            sin_out_q <= sin_out_d;
            cos_out_q <= cos_out_d;
            idx_out_q <= idx_out_d;
            done_q    <= done_d;
        end
    end

    assign TankX       = x_out_q;
    assign TankY       = y_out_q;
    assign Tank_size   = 10'(SIZE);
    assign sin_out     = sin_out_q;
    assign cos_out     = cos_out_q;
    assign angle_idx   = idx_out_q;
    assign update_done = done_q;
    assign dbg_state_o = state_q;
endmodule

// File: tb/tb_tank_motion.sv
// Directed bench for tank_motion: reset, turning, moving, wall clamp and reset mid-update.
module tb_tank_motion;
  logic       Clk = 1'b0;
  logic       Reset, frame_clk, fwd, back, rot_cw, rot_ccw;
  logic [9:0] TankX, TankY, Tank_size;
  logic [7:0] sin_out, cos_out;
  logic [4:0] angle_idx;
  logic       update_done;
  logic [2:0] dbg_state_o;

  int total = 0;
  int bad = 0;
  logic [9:0] exp_q[$];

`ifdef TANK_WALL_BOUNCE_EN
  localparam int LAT = 3 + 5;
  localparam int NSAT = 158;
`else
  localparam int LAT = 3 + 4;
  localparam int NSAT = 200;
`endif

  tank_motion dut (
    .Clk(Clk), .Reset(Reset), .frame_clk(frame_clk),
    .fwd(fwd), .back(back), .rot_cw(rot_cw), .rot_ccw(rot_ccw),
    .TankX(TankX), .TankY(TankY), .Tank_size(Tank_size),
    .sin_out(sin_out), .cos_out(cos_out), .angle_idx(angle_idx),
    .update_done(update_done), .dbg_state_o(dbg_state_o)
  );

  always #5 Clk = ~Clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, got, got, exp, exp);
    end
  endtask

  task automatic check_out(input string tag, input int x, input int y, input int idx,
                           input logic [7:0] s, input logic [7:0] c);
    check({tag, "_x"}, TankX, x);
    check({tag, "_y"}, TankY, y);
    check({tag, "_idx"}, angle_idx, idx);
    check({tag, "_sin"}, sin_out, s);
    check({tag, "_cos"}, cos_out, c);
  endtask

  task automatic check_reset(input string tag);
    check_out(tag, 320, 240, 0, 8'd0, 8'd64);
    check({tag, "_done"}, update_done, 0);
    check({tag, "_size"}, Tank_size, 4);
    check({tag, "_state"}, dbg_state_o, 0);
  endtask

  task automatic run_frame(input logic f, input logic b, input logic cw, input logic ccw);
    int n;
    @(negedge Clk);
    fwd = f; back = b; rot_cw = cw; rot_ccw = ccw;
    frame_clk = 1'b1;
    n = 0;
    do begin
      @(negedge Clk);
      n++;
    end while (!update_done && n < 20);
    check("latency", n, LAT);
    @(negedge Clk);
    check("pulse_width", update_done, 0);
    frame_clk = 1'b0;
    fwd = 1'b0; back = 1'b0; rot_cw = 1'b0; rot_ccw = 1'b0;
    repeat (4) @(negedge Clk);
  endtask

  initial begin
    int x;
    int n;
    int pulses;
    Reset = 1'b1; frame_clk = 1'b0;
    fwd = 1'b0; back = 1'b0; rot_cw = 1'b0; rot_ccw = 1'b0;
    repeat (3) @(negedge Clk);
    check_reset("reset");
    Reset = 1'b0;

    repeat (2) run_frame(0, 0, 0, 0);
    check_out("idle", 320, 240, 0, 8'd0, 8'd64);

    run_frame(1, 0, 0, 0);
    check_out("fwd0", 322, 240, 0, 8'd0, 8'd64);

    repeat (8) run_frame(0, 0, 1, 0);
    check_out("cw8", 322, 240, 8, 8'd64, 8'd0);

    run_frame(1, 0, 0, 0);
    check_out("fwd8", 322, 242, 8, 8'd64, 8'd0);

    // 8 down to 0 and then wrap to 31: cos(31)=63, sin(31)=-12.
    repeat (9) run_frame(0, 0, 0, 1);
    check_out("ccw_wrap", 322, 242, 31, 8'hF4, 8'd63);

    run_frame(1, 1, 1, 1);
    check_out("all_on", 322, 242, 31, 8'hF4, 8'd63);

    // PX = 20608-126 = 20482 -> 320; PY = 15488+24 = 15512 -> 242.
    run_frame(0, 1, 0, 0);
    check_out("back31", 320, 242, 31, 8'hF4, 8'd63);

    run_frame(0, 0, 1, 0);
    check_out("cw_wrap", 320, 242, 0, 8'd0, 8'd64);

    x = 320;
    for (int i = 0; i < NSAT; i++) begin
      x = (x + 2 > 635) ? 635 : x + 2;
      exp_q.push_back(10'(x));
      run_frame(1, 0, 0, 0);
      check("sat_x", TankX, exp_q.pop_front());
    end
`ifdef TANK_WALL_BOUNCE_EN
    check_out("wall", 635, 242, 16, 8'd0, 8'hC0);
`else
    check_out("wall", 635, 242, 0, 8'd0, 8'd64);
`endif

    @(negedge Clk);
    fwd = 1'b1;
    frame_clk = 1'b1;
    n = 0;
    while (dbg_state_o != 3'd3 && n < 20) begin
      @(negedge Clk);
      n++;
    end
    check("reach_move", (n < 20) ? 1 : 0, 1);
    Reset = 1'b1;
    frame_clk = 1'b0;
    fwd = 1'b0;
    @(negedge Clk);
    check_reset("mid_reset");
    Reset = 1'b0;
    pulses = 0;
    repeat (12) begin
      @(negedge Clk);
      if (update_done) pulses++;
    end
    check("no_pulse_after_reset", pulses, 0);
    check_out("after_reset", 320, 240, 0, 8'd0, 8'd64);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
